// File: rtl/eth_tx_arbiter_if.sv
// eth_tx_arbiter_if: AXI-Stream bundle with source (master) and sink (slave) views
interface eth_tx_arbiter_if #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tlast;
  logic                  tuser;
  modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: whole-frame round-robin arbiter of two AXI-Stream sources onto one MAC TX port; stalled-source watchdog built under TX_ARB_WATCHDOG_EN
module eth_tx_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT    = 256,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk156,
  input  logic                 eth_rst,
  eth_tx_arbiter_if.slave      s0_axis,
  eth_tx_arbiter_if.slave      s1_axis,
  eth_tx_arbiter_if.master     m_axis,
  output logic [CNT_WIDTH-1:0] pkt_cnt0,
  output logic [CNT_WIDTH-1:0] pkt_cnt1,
  output logic [15:0]          abort_cnt,
  output logic [7:0]           debug
);
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, ABORT} state_t;
  state_t state_q, state_d;
  logic last_q, last_d;
  logic [CNT_WIDTH-1:0] cnt0_q, cnt1_q;
  logic g0, g1, ab, elig0, elig1, fin, expire, drain0, drain1;
  // outputs are forced quiet while reset is held, independent of register contents
  assign g0 = ~eth_rst & (state_q == GRANT0);
  assign g1 = ~eth_rst & (state_q == GRANT1);
  assign ab = ~eth_rst & (state_q == ABORT);
  assign elig0 = s0_axis.tvalid & ~drain0;
  assign elig1 = s1_axis.tvalid & ~drain1;
  assign fin = (g0 | g1) & m_axis.tvalid & m_axis.tready & m_axis.tlast;
  assign m_axis.tvalid = g0 ? s0_axis.tvalid : g1 ? s1_axis.tvalid : ab;
  assign m_axis.tdata  = g0 ? s0_axis.tdata : g1 ? s1_axis.tdata : '0;
  assign m_axis.tkeep  = g0 ? s0_axis.tkeep : g1 ? s1_axis.tkeep : ab ? KEEP_WIDTH'(1) : '0;
  assign m_axis.tlast  = g0 ? s0_axis.tlast : g1 ? s1_axis.tlast : ab;
  assign m_axis.tuser  = g0 ? s0_axis.tuser : g1 ? s1_axis.tuser : ab;
  // a draining port swallows beats except while it is the one being aborted
  assign s0_axis.tready = g0 ? m_axis.tready : ~eth_rst & drain0 & ~(ab & ~last_q);
  assign s1_axis.tready = g1 ? m_axis.tready : ~eth_rst & drain1 & ~(ab & last_q);
  assign pkt_cnt0 = cnt0_q;
  assign pkt_cnt1 = cnt1_q;
  assign debug = eth_rst ? 8'h0 : {state_q, last_q, drain1, drain0, m_axis.tvalid, m_axis.tready, 1'b0};
  // arbitration in IDLE, frame end or watchdog exit from a grant, terminator handshake in ABORT
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    case (state_q)
      IDLE: begin
        if (elig0 && (!elig1 || last_q)) begin
          state_d = GRANT0;
          last_d = 1'b0;
        end else if (elig1) begin
          state_d = GRANT1;
          last_d = 1'b1;
        end
      end
      GRANT0, GRANT1: state_d = fin ? IDLE : expire ? ABORT : state_q;
      default: state_d = m_axis.tready ? IDLE : state_q;
    endcase
  end
  // state, round-robin pointer and per-port frame counters
  always_ff @(posedge clk156) begin
    if (eth_rst) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      if (fin & g0) cnt0_q <= cnt0_q + CNT_WIDTH'(1);
      if (fin & g1) cnt1_q <= cnt1_q + CNT_WIDTH'(1);
    end
  end
`ifdef TX_ARB_WATCHDOG_EN
  logic [15:0] idle_q, abort_q;
  logic drain0_q, drain1_q;
  assign expire = (g0 | g1) & ~m_axis.tvalid & (idle_q == 16'(TIMEOUT - 1));
  assign drain0 = drain0_q;
  assign drain1 = drain1_q;
  assign abort_cnt = abort_q;
  // idle-cycle watchdog, drain flags and saturating abort counter
  always_ff @(posedge clk156) begin
    if (eth_rst) begin
      idle_q <= '0;
      abort_q <= '0;
      drain0_q <= 1'b0;
      drain1_q <= 1'b0;
    end else begin
      idle_q <= ((g0 | g1) & ~m_axis.tvalid) ? idle_q + 16'd1 : 16'd0;
      if (ab & m_axis.tready & ~&abort_q) abort_q <= abort_q + 16'd1;
      drain0_q <= (expire & g0) | (drain0_q & ~(s0_axis.tvalid & s0_axis.tready & s0_axis.tlast));
      drain1_q <= (expire & g1) | (drain1_q & ~(s1_axis.tvalid & s1_axis.tready & s1_axis.tlast));
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign expire = 1'b0;
  assign drain0 = 1'b0;
  assign drain1 = 1'b0;
  assign abort_cnt = 16'h0;
`endif
endmodule
